// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants and the fetch-pair type.
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pair_t;
endpackage

// File: rtl/fq_storage.sv
// fq_storage: DEPTH x W register array; ports: clk, we/waddr/wdata write, raddr/rdata async read.
module fq_storage #(
  parameter int W     = 40,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch-to-decode {pc, instr} queue; ports: clk, rst_n, flush, push_* in, pop_ready in, pop_* out, count.
module if_fetch_queue
  import rv32i_pkg::*;
#(
  parameter int a_width = 8,
  parameter int i_width = 32,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push_valid,
  input  logic [a_width-1:0]         push_pc,
  input  logic [i_width-1:0]         push_instr,
  output logic                       push_ready,
  input  logic                       pop_ready,
  output logic                       pop_valid,
  output logic [a_width-1:0]         pop_pc,
  output logic [i_width-1:0]         pop_instr,
  output logic [a_width-1:0]         pop_pc_plus4,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [a_width+i_width-1:0] head;
  logic push_fire, pop_fire;
  assign push_ready = count != CW'(DEPTH);
  assign pop_valid  = count != '0;
  // flush wins over both handshakes, so neither side may fire in a flush cycle
  assign push_fire  = push_valid & push_ready & ~flush;
  assign pop_fire   = pop_valid & pop_ready & ~flush;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_fire) - CW'(pop_fire);
    end
  fq_storage #(.W(a_width + i_width), .DEPTH(DEPTH)) u_storage (
    .clk  (clk),
    .we   (push_fire),
    .waddr(wr_ptr),
    .wdata({push_pc, push_instr}),
    .raddr(rd_ptr),
    .rdata(head)
  );
  // storage is never reset, so the head is masked whenever the queue is empty
  assign pop_pc       = pop_valid ? head[a_width+i_width-1 -: a_width] : '0;
  assign pop_instr    = pop_valid ? head[i_width-1:0] : i_width'(RV_NOP);
  assign pop_pc_plus4 = pop_pc + a_width'(4);
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: table vectors, corner sequences and random traffic against a queue model.
module tb_if_fetch_queue;
  import rv32i_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 0, flush = 0, push_valid = 0, pop_ready = 0;
  logic [7:0] push_pc = '0;
  logic [31:0] push_instr = '0;
  logic push_ready, pop_valid;
  logic [7:0] pop_pc, pop_pc_plus4;
  logic [31:0] pop_instr;
  logic [1:0] count;
  int n_cmp = 0, n_bad = 0;
  fetch_pair_t q[$];
  if_fetch_queue #(.a_width(8), .i_width(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(push_valid), .push_pc(push_pc), .push_instr(push_instr), .push_ready(push_ready),
    .pop_ready(pop_ready), .pop_valid(pop_valid), .pop_pc(pop_pc), .pop_instr(pop_instr),
    .pop_pc_plus4(pop_pc_plus4), .count(count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic f, pv;
    logic [7:0] pc;
    logic [31:0] ins;
    logic pr;
    int e_cnt;
    logic e_rdy, e_val;
    logic [7:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;
  vec_t tbl[15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_model(input string tag);
    logic [7:0] epc;
    epc = q.size() != 0 ? 8'(q[0].pc) : 8'h00;
    chk({tag, " count"}, 32'(count), 32'(q.size()));
    chk({tag, " pop_valid"}, 32'(pop_valid), 32'(q.size() != 0));
    chk({tag, " push_ready"}, 32'(push_ready), 32'(q.size() != DEPTH));
    chk({tag, " pop_pc"}, 32'(pop_pc), 32'(epc));
    chk({tag, " pop_instr"}, pop_instr, q.size() != 0 ? q[0].instr : 32'h0000_0013);
    chk({tag, " pop_pc_plus4"}, 32'(pop_pc_plus4), 32'(8'(epc + 8'd4)));
  endtask
  task automatic apply(input logic f, input logic pv, input logic [7:0] pc, input logic [31:0] ins, input logic pr);
    bit pu, po;
    fetch_pair_t p;
    flush = f; push_valid = pv; push_pc = pc; push_instr = ins; pop_ready = pr;
    @(posedge clk);
    if (f) q.delete();
    else begin
      pu = pv && q.size() != DEPTH;
      po = pr && q.size() != 0;
      if (po) void'(q.pop_front());
      if (pu) begin
        p.pc = 32'(pc);
        p.instr = ins;
        q.push_back(p);
      end
    end
    #1;
  endtask
  initial begin
    tbl[0]  = '{0, 1, 8'h10, 32'h00500093, 1, 1, 1, 1, 8'h10, 32'h00500093};
    tbl[1]  = '{0, 0, 8'h00, 32'h0,        1, 0, 1, 0, 8'h00, 32'h00000013};
    tbl[2]  = '{0, 1, 8'h00, 32'h00000093, 0, 1, 1, 1, 8'h00, 32'h00000093};
    tbl[3]  = '{0, 1, 8'h04, 32'h00400093, 0, 2, 0, 1, 8'h00, 32'h00000093};
    tbl[4]  = '{0, 1, 8'h08, 32'h00800093, 0, 2, 0, 1, 8'h00, 32'h00000093};
    tbl[5]  = '{0, 1, 8'h08, 32'h00800093, 1, 1, 1, 1, 8'h04, 32'h00400093};
    tbl[6]  = '{0, 1, 8'h08, 32'h00800093, 1, 1, 1, 1, 8'h08, 32'h00800093};
    tbl[7]  = '{0, 0, 8'h00, 32'h0,        1, 0, 1, 0, 8'h00, 32'h00000013};
    tbl[8]  = '{0, 1, 8'h0C, 32'h00C00093, 0, 1, 1, 1, 8'h0C, 32'h00C00093};
    tbl[9]  = '{0, 1, 8'h20, 32'h02000093, 0, 2, 0, 1, 8'h0C, 32'h00C00093};
    tbl[10] = '{1, 1, 8'h30, 32'h03000093, 1, 0, 1, 0, 8'h00, 32'h00000013};
    tbl[11] = '{0, 1, 8'h40, 32'h04000093, 0, 1, 1, 1, 8'h40, 32'h04000093};
    tbl[12] = '{0, 0, 8'h00, 32'h0,        1, 0, 1, 0, 8'h00, 32'h00000013};
    tbl[13] = '{0, 1, 8'hFC, 32'h0FC00093, 0, 1, 1, 1, 8'hFC, 32'h0FC00093};
    tbl[14] = '{0, 0, 8'h00, 32'h0,        1, 0, 1, 0, 8'h00, 32'h00000013};
    #12;
    chk("reset count", 32'(count), 0);
    chk("reset pop_valid", 32'(pop_valid), 0);
    chk("reset push_ready", 32'(push_ready), 1);
    chk("reset pop_pc", 32'(pop_pc), 0);
    chk("reset pop_instr", pop_instr, 32'h0000_0013);
    chk("reset pop_pc_plus4", 32'(pop_pc_plus4), 4);
    rst_n = 1;
    for (int i = 0; i < 15; i++) begin
      string t;
      apply(tbl[i].f, tbl[i].pv, tbl[i].pc, tbl[i].ins, tbl[i].pr);
      t = $sformatf("vec%0d", i);
      chk({t, " count"}, 32'(count), 32'(tbl[i].e_cnt));
      chk({t, " push_ready"}, 32'(push_ready), 32'(tbl[i].e_rdy));
      chk({t, " pop_valid"}, 32'(pop_valid), 32'(tbl[i].e_val));
      chk({t, " pop_pc"}, 32'(pop_pc), 32'(tbl[i].e_pc));
      chk({t, " pop_instr"}, pop_instr, tbl[i].e_ins);
      chk({t, " pop_pc_plus4"}, 32'(pop_pc_plus4), 32'(8'(tbl[i].e_pc + 8'd4)));
    end
    q.delete();
    apply(0, 1, 8'h0C, 32'h00C00093, 0);
    chk_model("simul setup");
    for (int i = 0; i <= 2 * DEPTH; i++) begin
      logic [7:0] pc;
      pc = 8'h50 + 8'(4 * i);
      apply(0, 1, pc, {4'h0, pc, 20'h00093}, 1);
      chk_model($sformatf("simul%0d", i));
      chk($sformatf("simul%0d head", i), 32'(pop_pc), 32'(pc));
    end
    apply(0, 1, 8'h60, 32'h06000093, 0);
    chk_model("prereset");
    rst_n = 0;
    q.delete();
    #2;
    chk_model("async reset");
    #1 rst_n = 1;
    for (int i = 0; i < 400; i++) begin
      logic [7:0] pc;
      pc = 8'($urandom);
      apply($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, pc, $urandom, $urandom_range(0, 1) == 1);
      chk_model($sformatf("rand%0d", i));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
